wb_buffer: RTL and testbench

- Writeback buffer sitting directly upstream of the 32x32 register file.
- Accepts register results from the ALU and load paths and queues them in order.
- Drains one write per cycle onto the register file write port: data, address, active-low write enable.
- Provides a bypass lookup so operand reads see results still queued and not yet committed.

---
 rtl/wb_buffer.sv | 156 +++++++++++++++
 tb/tb_wb_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_buffer.sv
// rtl/wb_buffer.sv - writeback buffer queueing ALU/load results ahead of the register file
//
// Purpose: in-order FIFO of {addr, data} register results fed by the load and
// ALU paths (up to two per cycle). It drains one entry per cycle into an output
// register that drives the register file write port, and offers a two-port
// bypass lookup over everything not yet committed.
//
// Ports:
//   clk, rstd                 clock, synchronous active-high reset
//   ld_valid/ld_addr/ld_data  load result (older when both sources fire)
//   alu_valid/alu_addr/alu_data ALU result
//   in_ready                  room for two results this cycle
//   wr_reg/wr_addr/wren       register file write port, wren active-low
//   byp_addrN -> byp_hitN/byp_dataN  youngest pending value for a register
//   pend_count                entries queued, not counting the output register
module wb_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rstd,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    input  logic [DW-1:0]            ld_data,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_addr,
    input  logic [DW-1:0]            alu_data,
    output logic                     in_ready,
    output logic [DW-1:0]            wr_reg,
    output logic [AW-1:0]            wr_addr,
    output logic                     wren,
    input  logic [AW-1:0]            byp_addr1,
    input  logic [AW-1:0]            byp_addr2,
    output logic                     byp_hit1,
    output logic [DW-1:0]            byp_data1,
    output logic                     byp_hit2,
    output logic [DW-1:0]            byp_data2,
    output logic [$clog2(DEPTH):0]   pend_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_addr_q [DEPTH];
    logic [DW-1:0] mem_data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          wren_q, wren_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_reg_q, wr_reg_d;

    logic          acc_ld, acc_alu, deq;
    logic [PW-1:0] alu_slot;
    logic [PW-1:0] idx;

    // Ready only looks at the registered count: two free slots are guaranteed
    // without relying on this cycle's dequeue.
    assign in_ready = !rstd && (count_q <= CW'(DEPTH - 2));

    always_comb begin
        // Writes to r0 are accepted (handshake completes) but never stored.
        acc_ld    = ld_valid && in_ready && (ld_addr != '0);
        acc_alu   = alu_valid && in_ready && (alu_addr != '0);
        deq       = (count_q != '0);
        alu_slot  = tail_q + PW'(acc_ld);
        head_d    = head_q + PW'(deq);
        tail_d    = tail_q + PW'(acc_ld) + PW'(acc_alu);
        count_d   = count_q + CW'(acc_ld) + CW'(acc_alu) - CW'(deq);
        wren_d    = !deq;
        wr_addr_d = wr_addr_q;
        wr_reg_d  = wr_reg_q;
        if (deq) begin
            wr_addr_d = mem_addr_q[head_q];
            wr_reg_d  = mem_data_q[head_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wren_q    <= 1'b1;
            wr_addr_q <= '0;
            wr_reg_q  <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wren_q    <= wren_d;
            wr_addr_q <= wr_addr_d;
            wr_reg_q  <= wr_reg_d;
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by count/head.
    // acc_* are already gated by !rstd through in_ready.
    always_ff @(posedge clk) begin
        if (acc_ld) begin
            mem_addr_q[tail_q] <= ld_addr;
            mem_data_q[tail_q] <= ld_data;
        end
        if (acc_alu) begin
            mem_addr_q[alu_slot] <= alu_addr;
            mem_data_q[alu_slot] <= alu_data;
        end
    end

    // Bypass: scan oldest to youngest so later matches overwrite earlier ones.
    // The output register is older than every queued entry.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        idx       = '0;
        if (!wren_q && (wr_addr_q == byp_addr1)) begin
            byp_hit1  = 1'b1;
            byp_data1 = wr_reg_q;
        end
        if (!wren_q && (wr_addr_q == byp_addr2)) begin
            byp_hit2  = 1'b1;
            byp_data2 = wr_reg_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (mem_addr_q[idx] == byp_addr1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = mem_data_q[idx];
                end
                if (mem_addr_q[idx] == byp_addr2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = mem_data_q[idx];
                end
            end
        end
        if (byp_addr1 == '0) begin
            byp_hit1  = 1'b0;
            byp_data1 = '0;
        end
        if (byp_addr2 == '0) begin
            byp_hit2  = 1'b0;
            byp_data2 = '0;
        end
    end

    assign wren       = wren_q;
    assign wr_addr    = wr_addr_q;
    assign wr_reg     = wr_reg_q;
    assign pend_count = count_q;

endmodule

// File: tb/tb_wb_buffer.sv
// tb/tb_wb_buffer.sv - self-checking bench for wb_buffer
module tb_wb_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rstd;
    logic        ld_valid, alu_valid;
    logic [4:0]  ld_addr, alu_addr, byp_addr1, byp_addr2, wr_addr;
    logic [31:0] ld_data, alu_data, wr_reg, byp_data1, byp_data2;
    logic        in_ready, wren, byp_hit1, byp_hit2;
    logic [2:0]  pend_count;

    int n_vec = 0;
    int n_err = 0;

    wb_buffer #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk(clk), .rstd(rstd),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .in_ready(in_ready), .wr_reg(wr_reg), .wr_addr(wr_addr), .wren(wren),
        .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
        .byp_hit1(byp_hit1), .byp_data1(byp_data1),
        .byp_hit2(byp_hit2), .byp_data2(byp_data2),
        .pend_count(pend_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes as a plain queue, plus the output latch.
    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t        q[$];
    logic        m_wren;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    function automatic logic [32:0] mbyp(input logic [4:0] a);
        if (a == 5'd0) return 33'd0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].a == a) return {1'b1, q[i].d};
        if (!m_wren && m_addr == a) return {1'b1, m_data};
        return 33'd0;
    endfunction

    // Called at a negedge: drive, check against model, clock, update model.
    task automatic step(input logic rst, input logic lv, input logic [4:0] la,
                        input logic [31:0] ldd, input logic av, input logic [4:0] aa,
                        input logic [31:0] add, input logic [4:0] b1, input logic [4:0] b2);
        logic        rdy;
        logic [32:0] e1, e2;
        rstd = rst; ld_valid = lv; ld_addr = la; ld_data = ldd;
        alu_valid = av; alu_addr = aa; alu_data = add;
        byp_addr1 = b1; byp_addr2 = b2;
        #1;
        rdy = !rst && (q.size() <= DEPTH - 2);
        e1 = mbyp(b1);
        e2 = mbyp(b2);
        chk("m_in_ready", {31'd0, in_ready}, {31'd0, rdy});
        chk("m_wren", {31'd0, wren}, {31'd0, m_wren});
        chk("m_wr_addr", {27'd0, wr_addr}, {27'd0, m_addr});
        chk("m_wr_reg", wr_reg, m_data);
        chk("m_pend", {29'd0, pend_count}, q.size());
        chk("m_hit1", {31'd0, byp_hit1}, {31'd0, e1[32]});
        chk("m_data1", byp_data1, e1[31:0]);
        chk("m_hit2", {31'd0, byp_hit2}, {31'd0, e2[32]});
        chk("m_data2", byp_data2, e2[31:0]);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_wren = 1'b1; m_addr = '0; m_data = '0;
        end else begin
            if (q.size() > 0) begin
                m_wren = 1'b0; m_addr = q[0].a; m_data = q[0].d;
                void'(q.pop_front());
            end else begin
                m_wren = 1'b1;
            end
            if (rdy && lv && la != 0) q.push_back('{la, ldd});
            if (rdy && av && aa != 0) q.push_back('{aa, add});
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic lv; logic [4:0] la; logic [31:0] ld;
        logic av; logic [4:0] aa; logic [31:0] ad;
        logic [4:0] b1; logic [4:0] b2;
        logic e_rdy; logic e_wren; logic [4:0] e_addr; logic [31:0] e_reg;
        logic [2:0] e_pend; logic e_h1; logic [31:0] e_d1; logic e_h2; logic [31:0] e_d2;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // Single r5 write, then same-cycle ld/alu to r3 plus a dropped r0 write.
        tbl[0] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAA, 5'd5, 5'd0,
                   1'b1, 1'b1, 5'd0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5,
                   1'b1, 1'b1, 5'd0, 32'h0, 3'd1, 1'b1, 32'hAA, 1'b1, 32'hAA};
        tbl[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0,
                   1'b1, 1'b0, 5'd5, 32'hAA, 3'd0, 1'b1, 32'hAA, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd5, 5'd3,
                   1'b1, 1'b1, 5'd5, 32'hAA, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd3, 5'd0,
                   1'b1, 1'b1, 5'd5, 32'hAA, 3'd2, 1'b1, 32'h22, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0,
                   1'b1, 1'b0, 5'd3, 32'h11, 3'd1, 1'b1, 32'h22, 1'b0, 32'h0};
        tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0,
                   1'b1, 1'b0, 5'd3, 32'h22, 3'd0, 1'b1, 32'h22, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0,
                   1'b1, 1'b1, 5'd3, 32'h22, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0};

        rstd = 1'b1; ld_valid = 0; alu_valid = 0; ld_addr = 0; alu_addr = 0;
        ld_data = 0; alu_data = 0; byp_addr1 = 0; byp_addr2 = 0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wren", {31'd0, wren}, 32'd1);
        chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        chk("rst_wr_reg", wr_reg, 32'd0);
        chk("rst_pend", {29'd0, pend_count}, 32'd0);
        rstd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
            chk("idle_wren", {31'd0, wren}, 32'd1);
            chk("idle_pend", {29'd0, pend_count}, 32'd0);
            @(negedge clk);
        end

        for (int i = 0; i < 8; i++) begin
            ld_valid = tbl[i].lv; ld_addr = tbl[i].la; ld_data = tbl[i].ld;
            alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
            byp_addr1 = tbl[i].b1; byp_addr2 = tbl[i].b2;
            #1;
            chk($sformatf("t%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("t%0d_wren", i), {31'd0, wren}, {31'd0, tbl[i].e_wren});
            chk($sformatf("t%0d_wr_addr", i), {27'd0, wr_addr}, {27'd0, tbl[i].e_addr});
            chk($sformatf("t%0d_wr_reg", i), wr_reg, tbl[i].e_reg);
            chk($sformatf("t%0d_pend", i), {29'd0, pend_count}, {29'd0, tbl[i].e_pend});
            chk($sformatf("t%0d_hit1", i), {31'd0, byp_hit1}, {31'd0, tbl[i].e_h1});
            chk($sformatf("t%0d_data1", i), byp_data1, tbl[i].e_d1);
            chk($sformatf("t%0d_hit2", i), {31'd0, byp_hit2}, {31'd0, tbl[i].e_h2});
            chk($sformatf("t%0d_data2", i), byp_data2, tbl[i].e_d2);
            @(negedge clk);
        end

        // Model state matches where the table left the DUT.
        q.delete(); m_wren = 1'b1; m_addr = 5'd3; m_data = 32'h22;

        // Fill: two results per cycle for three cycles; third pair is refused.
        step(0, 1, 5'd1, 32'h101, 1, 5'd2, 32'h102, 5'd1, 5'd2);
        step(0, 1, 5'd4, 32'h104, 1, 5'd6, 32'h106, 5'd4, 5'd6);
        chk("fill_ready_low", {31'd0, in_ready}, 32'd0);
        step(0, 1, 5'd7, 32'h107, 1, 5'd8, 32'h108, 5'd7, 5'd8);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 5'd6, 5'd7);

        // Reset with three entries pending discards them.
        step(0, 1, 5'd9, 32'h209, 1, 5'd10, 32'h20A, 5'd9, 5'd10);
        step(0, 1, 5'd11, 32'h20B, 1, 5'd12, 32'h20C, 5'd11, 5'd12);
        chk("pre_rst_pend", {29'd0, pend_count}, 32'd3);
        step(1, 0, 0, 0, 0, 0, 0, 5'd11, 5'd12);
        chk("post_rst_wren", {31'd0, wren}, 32'd1);
        chk("post_rst_pend", {29'd0, pend_count}, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 5'd10, 5'd11);

        // Randomized traffic with small address space for collisions and r0.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
